// File: rtl/dm_store_buffer.sv
// Store write buffer: byte-masked stores queue in a circular FIFO, drain one per cycle to data memory,
// and pending bytes forward to loads. Optional STORE_TRACE_EN prints one line per drained store.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_be,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic [AW-1:0]            ld_addr,
    input  logic [31:0]              dm_rd,
    output logic [31:0]              ld_data,
    output logic [3:0]               ld_fwd,
    output logic                     dm_we,
    output logic [AW-1:0]            dm_addr,
    output logic [31:0]              dm_wd,
    output logic [3:0]               dm_be,
    output logic [31:0]              dm_pc,
    input  logic                     dm_ready,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [3:0]    r_be   [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_idx;

    assign st_ready = (r_count != CW'(DEPTH));
    assign dm_we    = (r_count != '0);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign w_push   = st_valid && st_ready;
    assign w_pop    = dm_we && dm_ready;

    assign dm_addr  = r_addr[r_rd_ptr];
    assign dm_wd    = r_data[r_rd_ptr];
    assign dm_be    = r_be[r_rd_ptr];
    assign dm_pc    = r_pc[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry payload needs no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= st_addr;
            r_data[r_wr_ptr] <= st_data;
            r_be[r_wr_ptr]   <= st_be;
            r_pc[r_wr_ptr]   <= st_pc;
        end
    end

    // Walk entries oldest to youngest from rd_ptr so the youngest match overwrites each lane last.
    always_comb begin
        ld_data = dm_rd;
        ld_fwd  = '0;
        w_idx   = r_rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PW'(k);
            if ((CW'(k) < r_count) && (r_addr[w_idx] == ld_addr)) begin
                for (int l = 0; l < 4; l++) begin
                    if (r_be[w_idx][l]) begin
                        ld_data[8*l +: 8] = r_data[w_idx][8*l +: 8];
                        ld_fwd[l]         = 1'b1;
                    end
                end
            end
        end
    end

`ifdef STORE_TRACE_EN
    logic [31:0] w_trace_wd;
    assign w_trace_wd = dm_wd & {{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}};

    always_ff @(posedge clk) begin
        if (!reset && w_pop)
            $display("@%08h: *%08h <= %08h", dm_pc, {{(30-AW){1'b0}}, dm_addr, 2'b00}, w_trace_wd);
    end
`else
    // Trace disabled: the buffer is silent in simulation.
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: directed vector table, then randomized traffic checked against a
// queue-based store-buffer model with its own data memory.
module tb_dm_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic [31:0]   st_pc;
    logic          st_ready;
    logic [AW-1:0] ld_addr;
    logic [31:0]   dm_rd;
    logic [31:0]   ld_data;
    logic [3:0]    ld_fwd;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wd;
    logic [3:0]    dm_be;
    logic [31:0]   dm_pc;
    logic          dm_ready;
    logic          empty;
    logic [2:0]    count;

    logic [31:0]   mem [4096];
    logic          use_mem;
    logic [31:0]   tbl_drd;

    assign dm_rd = use_mem ? mem[ld_addr] : tbl_drd;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
        .st_ready(st_ready),
        .ld_addr(ld_addr), .dm_rd(dm_rd), .ld_data(ld_data), .ld_fwd(ld_fwd),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be), .dm_pc(dm_pc),
        .dm_ready(dm_ready), .empty(empty), .count(count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst, sv;
        logic [11:0]   sa;
        logic [31:0]   sd;
        logic [3:0]    sbe;
        logic          rdy;
        logic [11:0]   la;
        logic [31:0]   drd;
        logic          chk;
        logic          e_rdy, e_we, e_empty;
        logic [2:0]    e_cnt;
        logic [31:0]   e_ld;
        logic [3:0]    e_fwd;
        logic [11:0]   e_da;
        logic [31:0]   e_dwd;
        logic [3:0]    e_dbe;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic sv, input logic [11:0] sa, input logic [31:0] sd,
        input logic [3:0] sbe, input logic rdy, input logic [11:0] la, input logic [31:0] drd,
        input logic c, input logic e_rdy, input logic e_we, input logic e_empty,
        input logic [2:0] e_cnt, input logic [31:0] e_ld, input logic [3:0] e_fwd,
        input logic [11:0] e_da, input logic [31:0] e_dwd, input logic [3:0] e_dbe);
        vec_t r;
        r.rst = rst; r.sv = sv; r.sa = sa; r.sd = sd; r.sbe = sbe; r.rdy = rdy;
        r.la = la; r.drd = drd; r.chk = c; r.e_rdy = e_rdy; r.e_we = e_we;
        r.e_empty = e_empty; r.e_cnt = e_cnt; r.e_ld = e_ld; r.e_fwd = e_fwd;
        r.e_da = e_da; r.e_dwd = e_dwd; r.e_dbe = e_dbe;
        return r;
    endfunction

    vec_t v[16];

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
        logic [31:0]   pc;
    } ent_t;

    ent_t q[$];

    function automatic logic [35:0] ref_load(input logic [AW-1:0] la);
        logic [31:0] d;
        logic [3:0]  f;
        d = mem[la];
        f = '0;
        foreach (q[i])
            if (q[i].a == la)
                for (int l = 0; l < 4; l++)
                    if (q[i].be[l]) begin
                        d[8*l +: 8] = q[i].d[8*l +: 8];
                        f[l] = 1'b1;
                    end
        return {f, d};
    endfunction

    task automatic model_edge();
        ent_t e;
        logic push, pop;
        push = st_valid && (q.size() < DEPTH);
        pop  = (q.size() > 0) && dm_ready;
        if (reset) begin
            q.delete();
        end else begin
            if (pop) begin
                e = q.pop_front();
                for (int l = 0; l < 4; l++)
                    if (e.be[l]) mem[e.a][8*l +: 8] = e.d[8*l +: 8];
            end
            if (push) begin
                e.a = st_addr; e.d = st_data; e.be = st_be; e.pc = st_pc;
                q.push_back(e);
            end
        end
    endtask

    task automatic check_model();
        logic [35:0] r;
        chk("rnd_st_ready", st_ready, q.size() != DEPTH);
        chk("rnd_dm_we",    dm_we,    q.size() != 0);
        chk("rnd_empty",    empty,    q.size() == 0);
        chk("rnd_count",    count,    q.size());
        if (q.size() > 0) begin
            chk("rnd_dm_addr", dm_addr, q[0].a);
            chk("rnd_dm_wd",   dm_wd,   q[0].d);
            chk("rnd_dm_be",   dm_be,   q[0].be);
            chk("rnd_dm_pc",   dm_pc,   q[0].pc);
        end
        r = ref_load(ld_addr);
        chk("rnd_ld_data", ld_data, r[31:0]);
        chk("rnd_ld_fwd",  ld_fwd,  r[35:32]);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 12'h010;
            1:       return 12'h011;
            2:       return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    initial begin
        reset = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_be = 0; st_pc = 0;
        ld_addr = 0; dm_ready = 0; use_mem = 0; tbl_drd = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

        //       rst sv sa      sd            sbe     rdy la      drd           c  rdy we emp cnt ld            fwd     da      dwd           dbe
        v[0]  = mk(1, 0, 12'h0,   32'h0,        4'h0, 0, 12'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,        4'h0, 12'h0,   32'h0,        4'h0);
        v[1]  = mk(0, 1, 12'h010, 32'h11223344, 4'hF, 0, 12'h010, 32'h0,        1, 1, 0, 1, 0, 32'h0,        4'h0, 12'h0,   32'h0,        4'h0);
        v[2]  = mk(0, 0, 12'h0,   32'h0,        4'h0, 0, 12'h010, 32'h0,        1, 1, 1, 0, 1, 32'h11223344, 4'hF, 12'h010, 32'h11223344, 4'hF);
        v[3]  = mk(0, 0, 12'h0,   32'h0,        4'h0, 1, 12'h010, 32'h0,        1, 1, 1, 0, 1, 32'h11223344, 4'hF, 12'h010, 32'h11223344, 4'hF);
        v[4]  = mk(0, 1, 12'h010, 32'hAAAAAAAA, 4'hF, 0, 12'h010, 32'h55555555, 1, 1, 0, 1, 0, 32'h55555555, 4'h0, 12'h0,   32'h0,        4'h0);
        v[5]  = mk(0, 1, 12'h010, 32'h000000BB, 4'h1, 0, 12'h010, 32'h0,        1, 1, 1, 0, 1, 32'hAAAAAAAA, 4'hF, 12'h010, 32'hAAAAAAAA, 4'hF);
        v[6]  = mk(0, 1, 12'h020, 32'h00CC0000, 4'h4, 0, 12'h010, 32'h0,        1, 1, 1, 0, 2, 32'hAAAAAABB, 4'hF, 12'h010, 32'hAAAAAAAA, 4'hF);
        v[7]  = mk(0, 0, 12'h0,   32'h0,        4'h0, 0, 12'h020, 32'h12345678, 1, 1, 1, 0, 3, 32'h12CC5678, 4'h4, 12'h010, 32'hAAAAAAAA, 4'hF);
        v[8]  = mk(0, 1, 12'h030, 32'h30303030, 4'hF, 0, 12'h030, 32'h0,        1, 1, 1, 0, 3, 32'h0,        4'h0, 12'h010, 32'hAAAAAAAA, 4'hF);
        v[9]  = mk(0, 1, 12'h040, 32'h40404040, 4'hF, 0, 12'h030, 32'h0,        1, 0, 1, 0, 4, 32'h30303030, 4'hF, 12'h010, 32'hAAAAAAAA, 4'hF);
        v[10] = mk(0, 1, 12'h040, 32'h40404040, 4'hF, 0, 12'h040, 32'h0,        1, 0, 1, 0, 4, 32'h0,        4'h0, 12'h010, 32'hAAAAAAAA, 4'hF);
        v[11] = mk(0, 1, 12'h040, 32'h40404040, 4'hF, 1, 12'h040, 32'h0,        1, 0, 1, 0, 4, 32'h0,        4'h0, 12'h010, 32'hAAAAAAAA, 4'hF);
        v[12] = mk(0, 1, 12'h040, 32'h40404040, 4'hF, 0, 12'h040, 32'h0,        1, 1, 1, 0, 3, 32'h0,        4'h0, 12'h010, 32'h000000BB, 4'h1);
        v[13] = mk(0, 0, 12'h0,   32'h0,        4'h0, 0, 12'h040, 32'h0,        1, 0, 1, 0, 4, 32'h40404040, 4'hF, 12'h010, 32'h000000BB, 4'h1);
        v[14] = mk(1, 1, 12'h050, 32'h05050505, 4'hF, 0, 12'h040, 32'h0,        1, 0, 1, 0, 4, 32'h40404040, 4'hF, 12'h010, 32'h000000BB, 4'h1);
        v[15] = mk(0, 0, 12'h0,   32'h0,        4'h0, 0, 12'h040, 32'h00000077, 1, 1, 0, 1, 0, 32'h00000077, 4'h0, 12'h0,   32'h0,        4'h0);

        #1;
        for (int i = 0; i < 16; i++) begin
            reset = v[i].rst; st_valid = v[i].sv; st_addr = v[i].sa; st_data = v[i].sd;
            st_be = v[i].sbe; st_pc = 32'h3000 + i; dm_ready = v[i].rdy;
            ld_addr = v[i].la; tbl_drd = v[i].drd;
            #2;
            if (v[i].chk) begin
                chk($sformatf("v%0d_st_ready", i), st_ready, v[i].e_rdy);
                chk($sformatf("v%0d_dm_we", i),    dm_we,    v[i].e_we);
                chk($sformatf("v%0d_empty", i),    empty,    v[i].e_empty);
                chk($sformatf("v%0d_count", i),    count,    v[i].e_cnt);
                chk($sformatf("v%0d_ld_data", i),  ld_data,  v[i].e_ld);
                chk($sformatf("v%0d_ld_fwd", i),   ld_fwd,   v[i].e_fwd);
                if (v[i].e_we) begin
                    chk($sformatf("v%0d_dm_addr", i), dm_addr, v[i].e_da);
                    chk($sformatf("v%0d_dm_wd", i),   dm_wd,   v[i].e_dwd);
                    chk($sformatf("v%0d_dm_be", i),   dm_be,   v[i].e_dbe);
                end
            end
            @(posedge clk);
            #1;
        end

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        use_mem = 1'b1;
        reset = 1'b1; st_valid = 1'b0; dm_ready = 1'b0;
        @(posedge clk);
        q.delete();
        #1;
        begin
            logic stalled;
            int   rdy_bias;
            stalled = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                rdy_bias = ((c / 200) % 2 == 0) ? 30 : 70;
                reset = ($urandom_range(0, 199) == 0);
                if (!stalled) begin
                    st_valid = ($urandom_range(0, 99) < 70);
                    st_addr  = pick_addr();
                    st_data  = $urandom;
                    st_be    = 4'($urandom);
                    st_pc    = $urandom;
                end
                dm_ready = ($urandom_range(0, 99) < rdy_bias);
                ld_addr  = pick_addr();
                #2;
                check_model();
                stalled = st_valid && !reset && (q.size() == DEPTH);
                @(posedge clk);
                model_edge();
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Write buffer between the datapath's store path and the data memory (4096 x 32-bit words, word-addressed, combinational read, write on posedge clk).
- Accepts byte-masked store requests and queues them in a FIFO.
- Drains one entry per cycle to the data-memory write port.
- Forwards pending store bytes to loads so the load path always sees program-order data.

Parameters:
- DEPTH, 4, number of store entries (power of 2, 2..16)
- AW, 12, word-address width (matches 4096-word data memory)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  store request present
- st_addr  in  AW  store word address
- st_data  in  32  store data, lane-aligned
- st_be  in  4  byte enables; bit i = bits [8i+7:8i]
- st_pc  in  32  PC of the store instruction, for trace
- st_ready  out  1  buffer can accept this cycle (= !full)
- ld_addr  in  AW  load word address
- dm_rd  in  32  data-memory read data at ld_addr
- ld_data  out  32  merged load data
- ld_fwd  out  4  per-lane flag: the lane came from the buffer
- dm_we  out  1  drain request to data memory
- dm_addr  out  AW  drain word address
- dm_wd  out  32  drain data
- dm_be  out  4  drain byte enables
- dm_pc  out  32  drain PC
- dm_ready  in  1  data memory accepts the write this cycle
- empty  out  1  no pending stores
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular FIFO with wr_ptr, rd_ptr and count registers.
- Reset: wr_ptr=0, rd_ptr=0, count=0. Entry contents are don't-care.
  - Outputs after reset: st_ready=1, empty=1, dm_we=0, ld_fwd=0, ld_data=dm_rd.
  - Reset mid-operation discards all pending stores. Reset dominates push and pop in the same cycle.
- Push: occurs when st_valid && st_ready. Entry {addr, data, be, pc} is written at wr_ptr; wr_ptr wraps modulo DEPTH.
  - st_valid with st_be=0 is accepted and occupies an entry; on drain it writes nothing.
- st_ready = (count != DEPTH).
  - It depends on registered state only, never on dm_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - The upstream holds st_* stable while st_valid && !st_ready.
- Drain: dm_we = (count != 0). dm_addr, dm_wd, dm_be and dm_pc come from the entry at rd_ptr, combinationally.
  - Pop occurs when dm_we && dm_ready; rd_ptr advances with wrap.
  - Drain order is strict FIFO.
  - Minimum latency from accepted store to dm_we: 1 cycle (entry visible the cycle after the push edge).
- Count update: push only +1; pop only -1; push and pop together unchanged.
- Data-memory side: writes only lanes with dm_be=1 and keeps the others.
- Forwarding is combinational, per lane i:
  - Take the youngest valid entry with addr == ld_addr and be[i]=1. That lane's byte drives ld_data lane i and ld_fwd[i]=1.
  - With no such entry, lane i = dm_rd lane i and ld_fwd[i]=0.
  - Lanes of one word may come from different entries.
  - The entry being popped in the current cycle still participates.
  - The store being pushed in the current cycle does NOT participate. The pipeline does not issue a load dependent on a same-cycle store.
- Empty: empty = (count == 0).
- Wrap: pointers wrap from DEPTH-1 to 0. Youngest-match priority follows age order (distance from rd_ptr), not raw index.

Optional Feature:
- Macro STORE_TRACE_EN.
- Defined: on every pop edge (not in reset), print one line: "@<dm_pc hex8>: *<byte address hex8> <= <masked word hex8>".
  - Byte address = {18'b0, dm_addr, 2'b00}.
  - Masked word = lanes with dm_be=0 printed as 00.
- Undefined: no simulation output. Logic is identical either way.

Test Plan:
- Reset, then push addr=0x010 data=0x11223344 be=F pc=0x3000 with dm_ready=0:
  - next cycle: dm_we=1, count=1, empty=0.
  - ld_addr=0x010 gives ld_data=0x11223344, ld_fwd=F.
  - raise dm_ready: pop, count=0.
- Push 0x010/0xAAAAAAAA/F, then 0x010/0x000000BB/be=1, dm_ready=0; ld_addr=0x010 with dm_rd=0 -> ld_data=0xAAAAAABB, ld_fwd=F.
- Push be=4'b0100 data=0x00CC0000 at 0x020; dm_rd=0x12345678 at ld_addr=0x020 -> ld_data=0x12CC5678, ld_fwd=4'b0100.
- dm_ready=0, push DEPTH=4 stores:
  - st_ready=0 and count=4; a 5th st_valid is held and not accepted.
  - dm_ready=1 for one cycle -> count=3, st_ready=1.
  - Drain order matches push order, including wrap.
- Full buffer, st_valid=1 and dm_ready=1 in the same cycle: pop only, count 4->3; the push is accepted the following cycle.
- 3 pending stores, assert reset for one cycle together with st_valid=1 -> count=0, dm_we=0, empty=1, ld_fwd=0 next cycle. With STORE_TRACE_EN defined, no trace line is printed.
